// File: rtl/mul_seq_unit_pkg.sv
// Shared encodings for the sequential RV32M multiplier: operation codes,
// controller states and the default datapath width.
package mul_seq_unit_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } mul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_FIX  = 2'b10,
    ST_DONE = 2'b11
  } mul_state_e;

endpackage

// File: rtl/mul_seq_unit_cla.sv
// N-bit carry-lookahead adder built from 4-bit lookahead groups chained by
// their group carries; Num must be a multiple of 4.
module CLA_N_Bit #(
  parameter int Num = 32
) (
  input  logic [Num-1:0] a,
  input  logic [Num-1:0] b,
  input  logic           cin,
  output logic [Num-1:0] sum,
  output logic           cout
);

  logic [Num-1:0] g_s;
  logic [Num-1:0] p_s;
  logic [Num:0]   c_s;

  assign g_s = a & b;
  assign p_s = a ^ b;

  // Per-group lookahead carries, each group seeded by the previous group carry
  always_comb begin
    c_s    = '0;
    c_s[0] = cin;
    for (int k = 0; k < Num / 4; k++) begin
      c_s[4*k+1] = g_s[4*k] | (p_s[4*k] & c_s[4*k]);
      c_s[4*k+2] = g_s[4*k+1] | (p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+3] = g_s[4*k+2] | (p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
      c_s[4*k+4] = g_s[4*k+3] | (p_s[4*k+3] & g_s[4*k+2])
                 | (p_s[4*k+3] & p_s[4*k+2] & g_s[4*k+1])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & g_s[4*k])
                 | (p_s[4*k+3] & p_s[4*k+2] & p_s[4*k+1] & p_s[4*k] & c_s[4*k]);
    end
  end

  assign sum  = p_s ^ c_s[Num-1:0];
  assign cout = c_s[Num];

endmodule

// File: rtl/mul_seq_unit.sv
// Radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU. Operands are
// reduced to magnitudes on accept and the sign is restored in the FIX state.
module mul_seq_unit
  import mul_seq_unit_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_in,
  output logic            ready_out,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            flush,
  output logic            valid_out,
  output logic [XLEN-1:0] result
);

  localparam logic [XLEN-1:0]   ONE_X    = XLEN'(1);
  localparam logic [2*XLEN-1:0] ONE_P    = (2*XLEN)'(1);
  localparam logic [CNT_W-1:0]  ONE_C    = CNT_W'(1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(XLEN - 1);

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic is_signed);
    magnitude = (is_signed && v[XLEN-1]) ? (~v + ONE_X) : v;
  endfunction

  mul_state_e        state_r, state_s;
  mul_op_e           op_s, op_r;
  logic [XLEN-1:0]   mcand_r;
  logic [2*XLEN-1:0] prod_r;
  logic [2*XLEN-1:0] step_s;
  logic [2*XLEN-1:0] fix_prod_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              neg_r;
  logic              valid_r;
  logic [XLEN-1:0]   result_r;
  logic [XLEN-1:0]   sum_s;
  logic              cout_s;
  logic              rs1_signed_s;
  logic              rs2_signed_s;
  logic              accept_s;

  assign op_s         = mul_op_e'(op);
  assign rs1_signed_s = (op_s == OP_MULH) || (op_s == OP_MULHSU);
  assign rs2_signed_s = (op_s == OP_MULH);
  assign accept_s     = (state_r == ST_IDLE) && valid_in && !flush;

  CLA_N_Bit #(.Num(XLEN)) u_cla (
    .a    (prod_r[2*XLEN-1:XLEN]),
    .b    (mcand_r),
    .cin  (1'b0),
    .sum  (sum_s),
    .cout (cout_s)
  );

  // The adder carry becomes the new top product bit after the shift
  assign step_s     = prod_r[0] ? {cout_s, sum_s, prod_r[XLEN-1:1]}
                                : {1'b0, prod_r[2*XLEN-1:1]};
  assign fix_prod_s = neg_r ? (~prod_r + ONE_P) : prod_r;

  // Controller next-state
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_CALC;
        else          state_s = ST_IDLE;
      end
      ST_CALC: begin
        if (flush)                  state_s = ST_IDLE;
        else if (cnt_r == LAST_CNT) state_s = ST_FIX;
        else                        state_s = ST_CALC;
      end
      ST_FIX: begin
        if (flush) state_s = ST_IDLE;
        else       state_s = ST_DONE;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register, datapath and registered result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= ST_IDLE;
      op_r     <= OP_MUL;
      mcand_r  <= '0;
      prod_r   <= '0;
      cnt_r    <= '0;
      neg_r    <= 1'b0;
      valid_r  <= 1'b0;
      result_r <= '0;
    end else begin
      state_r <= state_s;
      valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            op_r    <= op_s;
            mcand_r <= magnitude(rs1, rs1_signed_s);
            prod_r  <= {{XLEN{1'b0}}, magnitude(rs2, rs2_signed_s)};
            cnt_r   <= '0;
            neg_r   <= (rs1_signed_s & rs1[XLEN-1]) ^ (rs2_signed_s & rs2[XLEN-1]);
          end
        end
        ST_CALC: begin
          if (!flush) begin
            prod_r <= step_s;
            cnt_r  <= cnt_r + ONE_C;
          end
        end
        ST_FIX: begin
          if (!flush) begin
            prod_r   <= fix_prod_s;
            result_r <= (op_r == OP_MUL) ? fix_prod_s[XLEN-1:0] : fix_prod_s[2*XLEN-1:XLEN];
            valid_r  <= 1'b1;
          end
        end
        ST_DONE: valid_r <= 1'b0;
        default: valid_r <= 1'b0;
      endcase
    end
  end

  assign ready_out = (state_r == ST_IDLE);
  assign valid_out = valid_r & ~flush;
  assign result    = result_r;

endmodule

// File: tb/tb_mul_seq_unit.sv
// Directed self-checking bench for mul_seq_unit: products with hand-computed
// results, fixed latency, flush abort and asynchronous reset mid-operation.
module tb_mul_seq_unit;

  logic        clk;
  logic        rst;
  logic        valid_in;
  logic        ready_out;
  logic [1:0]  op;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        flush;
  logic        valid_out;
  logic [31:0] result;

  int total;
  int bad;

  mul_seq_unit #(.XLEN(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .op        (op),
    .rs1       (rs1),
    .rs2       (rs2),
    .flush     (flush),
    .valid_out (valid_out),
    .result    (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!ready_out && n < 100) begin
      @(posedge clk); #1; n++;
    end
    @(negedge clk);
    valid_in = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int n;
    issue(o, a, b);
    total++;
    if (ready_out !== 1'b0) begin
      bad++; $display("FAIL %s ready_after_accept got=%b want=0", name, ready_out);
    end
    n = 0;
    while (valid_out !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    total++;
    if (n !== 33) begin
      bad++; $display("FAIL %s latency got=%0d want=33", name, n);
    end
    total++;
    if (result !== exp) begin
      bad++; $display("FAIL %s result got=%h want=%h", name, result, exp);
    end
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0 || ready_out !== 1'b1) begin
      bad++; $display("FAIL %s single_pulse valid=%b ready=%b want valid=0 ready=1", name, valid_out, ready_out);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_in = 1'b0; flush = 1'b0; op = 2'b00; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (valid_out !== 1'b0 || result !== 32'h0000_0000 || ready_out !== 1'b1) begin
      bad++; $display("FAIL reset_state valid=%b result=%h ready=%b want 0/00000000/1", valid_out, result, ready_out);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_products();
    run_op("mul_7x6",        2'b00, 32'd7,         32'd6,         32'h0000_002A);
    run_op("mulhu_ff",       2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("mul_ff",         2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    run_op("mulh_m1m1",      2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
    run_op("mulh_min_min",   2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run_op("mulhsu_m1x2",    2'b10, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF);
    run_op("mul_m5x3",       2'b00, 32'hFFFF_FFFB, 32'd3,         32'hFFFF_FFF1);
    run_op("mulh_m3x5",      2'b01, 32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF);
    run_op("mulhu_min_x2",   2'b11, 32'h8000_0000, 32'd2,         32'h0000_0001);
    run_op("mulhsu_2_x_neg", 2'b10, 32'd2,         32'hFFFF_FFFF, 32'h0000_0001);
  endtask

  task automatic test_flush();
    int seen;
    // result currently holds 0x00000001 from the last product
    issue(2'b00, 32'd100, 32'd100);
    repeat (8) @(posedge clk);
    @(negedge clk);
    valid_in = 1'b1; op = 2'b00; rs1 = 32'd9; rs2 = 32'd9;
    @(posedge clk); #1;
    total++;
    if (ready_out !== 1'b0) begin
      bad++; $display("FAIL busy_ignore ready got=%b want=0", ready_out);
    end
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1;
    total++;
    if (valid_out !== 1'b0) begin
      bad++; $display("FAIL flush_valid got=%b want=0", valid_out);
    end
    flush = 1'b0; valid_in = 1'b0;
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL flush_to_idle ready got=%b want=1", ready_out);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (valid_out === 1'b1) seen++;
    end
    total++;
    if (seen !== 0 || result !== 32'h0000_0001) begin
      bad++; $display("FAIL flush_no_pulse pulses=%0d result=%h want 0/00000001", seen, result);
    end
    // flush in IDLE must block acceptance
    @(negedge clk); valid_in = 1'b1; flush = 1'b1; op = 2'b00; rs1 = 32'd4; rs2 = 32'd4;
    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0;
    total++;
    if (ready_out !== 1'b1) begin
      bad++; $display("FAIL flush_blocks_accept ready got=%b want=1", ready_out);
    end
    run_op("after_flush", 2'b00, 32'd12, 32'd11, 32'h0000_0084);
  endtask

  task automatic test_async_reset();
    issue(2'b00, 32'd1000, 32'd1000);
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++;
    if (valid_out !== 1'b0 || result !== 32'h0000_0000 || ready_out !== 1'b1) begin
      bad++; $display("FAIL async_reset valid=%b result=%h ready=%b want 0/00000000/1", valid_out, result, ready_out);
    end
    @(negedge clk); rst = 1'b0;
    run_op("mul_3x5", 2'b00, 32'd3, 32'd5, 32'h0000_000F);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_products();
    test_flush();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
